mixffn_seq: RTL
===============

# mixffn_seq

Stage sequencer and stream adapter on the initiator side of the `mixffn` pipeline (fc1 → dwconv → gelu → fc2). It accepts input elements over a valid/ready stream and drives `in_data` and the four per-stage `in_valid_*` strobes. It advances one stage each time that stage's `out_valid_*` completion flag is seen, then captures the fc2 `sum` and presents it on a valid/ready result stream. One token is in flight at a time. Each stage wait is guarded by a timeout.

## Interface
- `IN_LEN`, default 9: input beats per token fed to fc1 (1..255).
- `TIMEOUT`, default 1024: maximum cycles spent in any WAIT state (2..65535).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `s_valid`  in  1: upstream element valid.
- `s_ready`  out  1: upstream ready.
- `s_data`  in  10: upstream element.
- `in_data`  out  10: element to `mixffn` fc1.
- `in_valid_fc1`, `in_valid_dwconv`, `in_valid_gelu`, `in_valid_fc2`  out  1 each: stage start strobes.
- `out_valid_fc1`, `out_valid_dwconv`, `out_valid_gelu`, `out_valid`  in  1 each: stage completion flags.
- `sum`  in  16: fc2 result, valid when `out_valid` is high.
- `m_valid`  out  1: result valid.
- `m_ready`  in  1: downstream ready.
- `m_data`  out  16: captured result.
- `busy`  out  1: high in any state other than IDLE.
- `timeout_err`  out  1: sticky timeout flag; cleared only by `rst`.
- `tokens_done`  out  16: count of results accepted downstream; wraps.

## Operation
- States: IDLE, LOAD, WAIT_FC1, WAIT_DW, WAIT_GELU, WAIT_FC2, OUT.
- IDLE:
  - `s_ready`=0.
  - Goes to LOAD when `s_valid`=1; no beat is consumed in that cycle.
- LOAD:
  - `s_ready`=1 (combinational from state).
  - Each accepted beat (`s_valid`&`s_ready`) registers `in_data`←`s_data`, so `in_valid_fc1`=1 in the next cycle.
  - An 8-bit beat counter counts accepted beats. The IN_LEN-th accepted beat moves the FSM to WAIT_FC1.
  - Gaps in `s_valid` are allowed; `in_valid_fc1` is 0 during gap cycles.
- WAIT_FC1: `out_valid_fc1`=1 → `in_valid_dwconv` pulses for one cycle on the next cycle; move to WAIT_DW.
- WAIT_DW: `out_valid_dwconv`=1 → one-cycle `in_valid_gelu` pulse; move to WAIT_GELU.
- WAIT_GELU: `out_valid_gelu`=1 → one-cycle `in_valid_fc2` pulse; move to WAIT_FC2.
- WAIT_FC2: `out_valid`=1 → `m_data`←`sum`; move to OUT.
- OUT:
  - `m_valid`=1; `m_data` is held stable until `m_ready`=1.
  - On handshake: `tokens_done`+1 (16-bit wrap, FFFF→0000), then IDLE.
- Timeout:
  - A 16-bit wait counter clears on entry to each WAIT state and increments every cycle in that state.
  - If it reaches TIMEOUT-1 without the expected flag: set `timeout_err`, drop the token, go to IDLE.
  - If the flag and the timeout arrive in the same cycle, the flag wins.
- Completion flags not matching the current state are ignored; they cause no state change and no error.
- No `s_ready` in WAIT_*/OUT: upstream is back-pressured until the token completes.

## Timing
- Reset values: `s_ready`=0, `in_data`=0, all `in_valid_*`=0, `m_valid`=0, `m_data`=0, `busy`=0, `timeout_err`=0, `tokens_done`=0. State=IDLE.
- Assertion of `rst` mid-token aborts immediately with no output; all strobes drop asynchronously.
- `in_valid_*` and `in_data` are registered, with 1 cycle from accepted beat or completion flag to strobe.
- Each strobe lasts exactly one cycle per event; at most one `in_valid_*` is high in any cycle.
- Controller overhead per token, excluding stage latencies and stream stalls:
  - 1 cycle IDLE→LOAD;
  - IN_LEN load cycles;
  - 1 strobe cycle per stage transition;
  - 1 cycle minimum in OUT.
- `m_valid` rises the cycle after `out_valid` is sampled. If `m_ready`=1 already, OUT lasts 1 cycle.
- `busy` is a registered state decode.

## Test plan
- Nominal token, IN_LEN=9:
  - Stimulus: 9 beats `s_data`=1..9 with no gaps; the stage model raises each flag 5 cycles after its strobe; `sum`=0x1234; `m_ready`=1.
  - Required: 9 `in_valid_fc1` pulses carrying 1..9 in order; one pulse each of dwconv, gelu and fc2 in that order; `m_data`=0x1234; `tokens_done`=1.
- Upstream gaps:
  - Stimulus: `s_valid` toggled 1,0,1,0.
  - Required: `in_valid_fc1` is 0 in gap cycles; still exactly 9 beats are forwarded.
- Output backpressure:
  - Stimulus: `m_ready`=0 for 20 cycles.
  - Required: `m_valid` is held, `m_data` is stable and `s_ready` stays 0; the handshake occurs on the cycle `m_ready` goes to 1.
- Timeout:
  - Stimulus: `out_valid_gelu` is never raised; TIMEOUT=16.
  - Required: `timeout_err`=1 after 16 cycles in WAIT_GELU; no fc2 strobe; FSM in IDLE; the next token completes normally with `timeout_err` still 1.
- Spurious and simultaneous flags:
  - Stimulus: `out_valid` raised during LOAD; separately, `out_valid_fc1` raised on the exact timeout cycle.
  - Required: the first is ignored; for the second, `in_valid_dwconv` pulses and `timeout_err` stays 0.
- Reset mid-token and count wrap:
  - Stimulus: `rst` pulsed during WAIT_DW; separately, `tokens_done` preset to 0xFFFF by running 65535 tokens, then one more token.
  - Required: all outputs return to their reset values with no `m_valid`; `tokens_done`=0x0000 after the extra token.

Source files
------------

// File: rtl/mixffn_seq.sv
// rtl/mixffn_seq.sv - stage sequencer and stream adapter driving the mixffn fc1/dwconv/gelu/fc2 pipeline
// One token in flight: load IN_LEN beats, step through each stage's completion, present fc2 sum downstream.
module mixffn_seq #(
    parameter int IN_LEN  = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [9:0]  s_data,
    output logic [9:0]  in_data,
    output logic        in_valid_fc1,
    output logic        in_valid_dwconv,
    output logic        in_valid_gelu,
    output logic        in_valid_fc2,
    input  logic        out_valid_fc1,
    input  logic        out_valid_dwconv,
    input  logic        out_valid_gelu,
    input  logic        out_valid,
    input  logic [15:0] sum,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] tokens_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_FC1,
        S_WAIT_DW,
        S_WAIT_GELU,
        S_WAIT_FC2,
        S_OUT
    } state_t;

    localparam logic [7:0]  LAST_BEAT  = 8'(IN_LEN - 1);
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] wait_q, wait_d;
    logic [9:0]  in_data_q, in_data_d;
    logic [3:0]  strobe_q, strobe_d;   // {fc2, gelu, dwconv, fc1}
    logic [15:0] m_data_q, m_data_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] tokens_q, tokens_d;
    logic        flag;
    logic        timed_out;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        in_data_d     = in_data_q;
        strobe_d      = 4'b0000;
        m_data_d      = m_data_q;
        timeout_err_d = timeout_err_q;
        tokens_d      = tokens_q;
        flag          = 1'b0;

        // Only the flag belonging to the stage being waited on is looked at.
        case (state_q)
            S_WAIT_FC1:  flag = out_valid_fc1;
            S_WAIT_DW:   flag = out_valid_dwconv;
            S_WAIT_GELU: flag = out_valid_gelu;
            S_WAIT_FC2:  flag = out_valid;
            default:     flag = 1'b0;
        endcase
        timed_out = (wait_q == WAIT_LIMIT) && !flag;

        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_LOAD;
                    beat_d  = 8'd0;
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    in_data_d   = s_data;
                    strobe_d[0] = 1'b1;
                    beat_d      = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_WAIT_FC1;
                        wait_d  = 16'd0;
                    end
                end
            end
            S_WAIT_FC1, S_WAIT_DW, S_WAIT_GELU, S_WAIT_FC2: begin
                wait_d = wait_q + 16'd1;
                if (flag) begin
                    wait_d = 16'd0;
                    case (state_q)
                        S_WAIT_FC1: begin
                            strobe_d[1] = 1'b1;
                            state_d     = S_WAIT_DW;
                        end
                        S_WAIT_DW: begin
                            strobe_d[2] = 1'b1;
                            state_d     = S_WAIT_GELU;
                        end
                        S_WAIT_GELU: begin
                            strobe_d[3] = 1'b1;
                            state_d     = S_WAIT_FC2;
                        end
                        default: begin
                            m_data_d = sum;
                            state_d  = S_OUT;
                        end
                    endcase
                end else if (timed_out) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    tokens_d = tokens_q + 16'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_q        <= 8'd0;
            wait_q        <= 16'd0;
            in_data_q     <= 10'd0;
            strobe_q      <= 4'b0000;
            m_data_q      <= 16'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tokens_q      <= 16'd0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            in_data_q     <= in_data_d;
            strobe_q      <= strobe_d;
            m_data_q      <= m_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tokens_q      <= tokens_d;
        end
    end

    assign s_ready         = (state_q == S_LOAD);
    assign m_valid         = (state_q == S_OUT);
    assign in_data         = in_data_q;
    assign in_valid_fc1    = strobe_q[0];
    assign in_valid_dwconv = strobe_q[1];
    assign in_valid_gelu   = strobe_q[2];
    assign in_valid_fc2    = strobe_q[3];
    assign m_data          = m_data_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
    assign tokens_done     = tokens_q;

endmodule
